// File: rtl/regfile_write_sched_if.sv
// Write-request bundle between the execute/memory stages and the write scheduler.
// Upstream (master) drives both write streams; the scheduler (slave) returns stall.
interface regfile_write_sched_if #(
   parameter int AW = 4,
   parameter int DW = 16
);
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_data;
   logic          a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_data;
   logic          stall;

   modport master (output d_we, d_addr, d_data, a_we, a_addr, a_data, input stall);
   modport slave  (input d_we, d_addr, d_data, a_we, a_addr, a_data, output stall);
endinterface

// File: rtl/regfile_write_sched.sv
// Serialises D_Bus/D_Addr register writes onto a one-write-per-cycle register file.
// Non-colliding writes pass through with zero latency; a collision holds A for one stalled cycle.
module regfile_write_sched #(
   parameter int AW    = 4,
   parameter int DW    = 16,
   parameter int CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   regfile_write_sched_if.slave      req,
   output logic                      rf_reg3_write,
   output logic [AW-1:0]             rf_reg3_addr,
   output logic [DW-1:0]             rf_reg3_bus,
   output logic                      rf_reg4_write,
   output logic [AW-1:0]             rf_reg4_addr,
   output logic [DW-1:0]             rf_reg4_bus,
   input  logic [AW-1:0]             rd1_addr,
   input  logic [AW-1:0]             rd2_addr,
   input  logic [DW-1:0]             rf_rd1,
   input  logic [DW-1:0]             rf_rd2,
   output logic [DW-1:0]             rd1_data,
   output logic [DW-1:0]             rd2_data,
   output logic [CNT_W-1:0]          collisions
);
   typedef enum logic {IDLE, HOLD} state_t;

   state_t        state;
   logic [AW-1:0] hold_addr;
   logic [DW-1:0] hold_data;
   logic          split;

   // Same-address pairs are not split: D is later in program order and simply wins.
   assign split = req.d_we && req.a_we && (req.d_addr != req.a_addr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hold_addr  <= '0;
         hold_data  <= '0;
         collisions <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (split) begin
                  state     <= HOLD;
                  hold_addr <= req.a_addr;
                  hold_data <= req.a_data;
                  if (collisions != '1)
                     collisions <= collisions + 1'b1;
               end
            end
            HOLD:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign req.stall = (state == HOLD);

   always_comb begin
      rf_reg3_write = 1'b0;
      rf_reg3_addr  = req.d_addr;
      rf_reg3_bus   = req.d_data;
      rf_reg4_write = 1'b0;
      rf_reg4_addr  = req.a_addr;
      rf_reg4_bus   = req.a_data;
      if (state == HOLD) begin
         rf_reg4_addr  = hold_addr;
         rf_reg4_bus   = hold_data;
         rf_reg4_write = !rst;
      end else if (!rst) begin
         rf_reg3_write = req.d_we;
         rf_reg4_write = req.a_we && !req.d_we;
      end
   end

   // The register file only sees the held value after the next edge, so bypass it meanwhile.
   assign rd1_data = (state == HOLD && rd1_addr == hold_addr) ? hold_data : rf_rd1;
   assign rd2_data = (state == HOLD && rd2_addr == hold_addr) ? hold_data : rf_rd2;
endmodule
